delay_pipe: RTL and testbench
=============================

Name: delay_pipe

Overview:
Parametrised, multi-bit, stallable register delay line with a runtime-selectable tap, per-word valid tracking, flush, and bitwise edge detection on the selected output. It generalises the fixed two-flop sample chain used for input capture, and serves as the common pipeline-alignment and input-capture stage for datapaths and testbench-driven blocks. It sits between an asynchronous or upstream source and any consumer that needs a delay of 1..DEPTH cycles.

Parameters:
WIDTH, 1, data bits per word.
DEPTH, 2, number of register stages; this is the maximum delay. Must be at least 1.
RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  shift enable; when 0 the pipeline stalls.
flush  input  1  synchronous invalidate of all stages.
din  input  WIDTH  input word.
din_valid  input  1  qualifies din.
tap_sel  input  TAP_W  selected delay in cycles; TAP_W = $clog2(DEPTH+1).
dout  output  WIDTH  word at the selected tap.
dout_valid  output  1  valid bit at the selected tap.
rise  output  WIDTH  per-bit 0->1 change of dout since the previous valid output.
fall  output  WIDTH  per-bit 1->0 change of dout since the previous valid output.

Behaviour:
- Storage: data stages stg[0..DEPTH-1], valid stages v[0..DEPTH-1], history register last_q[WIDTH], history flag last_ok.
- Reset, asynchronous on rst_n=0, effective immediately:
  - stg=RESET_VAL, v=0, last_q=RESET_VAL, last_ok=0.
  - Outputs: dout=RESET_VAL, dout_valid=0, rise=0, fall=0.
- Shift, at a posedge with en=1 and flush=0:
  - stg[0]<=din, v[0]<=din_valid.
  - stg[i]<=stg[i-1] and v[i]<=v[i-1] for i=1..DEPTH-1.
  - stg[0] takes the pre-edge din value, so there is no same-edge pass-through (nonblocking semantics). The chain must never collapse into fewer stages.
- Stall, en=0 and flush=0: all stg, v, last_q and last_ok hold.
- Flush, at a posedge with flush=1 (priority over en):
  - v[*]<=0 and last_ok<=0.
  - stg contents are left unchanged.
  - din and din_valid in that cycle are discarded.
- Tap select:
  - eff_tap = tap_sel clamped to 1..DEPTH; 0 is treated as 1, and values above DEPTH are treated as DEPTH.
  - dout=stg[eff_tap-1] and dout_valid=v[eff_tap-1], both through a combinational mux of registered values.
  - A tap_sel change takes effect on dout in the same cycle. Data already in flight is not disturbed.
- Latency: a word sampled at enabled edge k appears on dout after enabled edge k+eff_tap-1. That is eff_tap enabled edges counting the capture edge, with stalled cycles not counted.
- History update, at a posedge with en=1, flush=0 and dout_valid=1 (evaluated pre-edge): last_q<=dout, last_ok<=1.
- Edge flags (combinational):
  - rise = dout_valid & last_ok ? (dout & ~last_q) : 0.
  - fall = dout_valid & last_ok ? (~dout & last_q) : 0.
  - Gaps of invalid words between two valid words do not reset the history; only a flush or reset does.
  - With en=0 the flags stay stable, because dout and last_q hold.
- Simultaneous events:
  - flush with en=1: flush wins.
  - rst_n low overrides everything, including mid-stall or mid-flush.
- Release of rst_n is synchronised externally; the block adds no reset synchroniser.

Decomposition:
- Package delay_pipe_pkg:
  - function tap_w(depth) returning $clog2(depth+1).
  - function clamp_tap(sel, depth).
- Sub-module edge_detect (WIDTH): holds last_q/last_ok, produces rise/fall.
  - Inputs: clk, rst_n, upd, clr, d, d_valid.
  - Reused by other capture blocks.
- The top level contains the stage array, valid chain, flush logic and tap mux.

Test Plan:
- Reset (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5): assert rst_n=0 between clock edges -> dout=8'hA5, dout_valid=0, rise=fall=0 immediately, without a clock edge.
- Latency (tap_sel=2, en=1, din_valid=1): stream 11,22,33 at edges 1-3 -> dout=11 valid after edge 2, 22 after edge 3, 33 after edge 4. Repeat with tap_sel=4 -> 11 appears after edge 4.
- Stall: en=0 for 3 cycles mid-stream at tap 3 -> dout, dout_valid, rise and fall frozen; after en=1 the sequence resumes with no word lost or duplicated.
- Flush: flush=1 with en=1 while 4 valid words are in flight -> dout_valid=0 at every tap on the next cycle. The next valid din appears after eff_tap edges, and its rise/fall are 0 because history was cleared.
- Clamp: tap_sel=0 behaves as 1; tap_sel=7 behaves as 4 (dout==stg[3]). Switching tap_sel 4->1 mid-stream changes dout combinationally with no register disturbance.
- Edges (WIDTH=1, DEPTH=2, tap 2): din 0,1,1,0 -> rise=1 on the cycle dout becomes 1, fall=1 on the cycle dout returns to 0, otherwise 0. An invalid word inserted between the 1 and the 0 still yields fall=1.

Source files
------------

// File: rtl/delay_pipe_pkg.sv
// Shared helpers for the delay_pipe family: tap-select width and tap clamping.
package delay_pipe_pkg;

  // Number of bits needed to express a tap in 0..depth.
  function automatic int tap_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Map a raw tap select onto the legal delay range 1..depth.
  function automatic int clamp_tap(input int sel, input int depth);
    int r;
    if (sel < 1) begin
      r = 1;
    end else if (sel > depth) begin
      r = depth;
    end else begin
      r = sel;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Per-bit rise/fall detector against the last valid word seen.
// History survives invalid gaps; only clr or reset forgets it.
module edge_detect
  import delay_pipe_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] last_d;
  logic             last_ok_q;
  logic             last_ok_d;

  // Next-state for the history word: clear wins over update, else hold.
  always_comb begin
    last_d    = last_q;
    last_ok_d = last_ok_q;
    if (clr) begin
      last_ok_d = 1'b0;
    end else if (upd) begin
      last_d    = d;
      last_ok_d = 1'b1;
    end else begin
      last_ok_d = last_ok_q;
    end
  end

  // History registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= RESET_VAL;
      last_ok_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      last_ok_q <= last_ok_d;
    end
  end

  // Edge flags only when both the current word and the history are trustworthy.
  always_comb begin
    if (d_valid && last_ok_q) begin
      rise = d & ~last_q;
      fall = ~d & last_q;
    end else begin
      rise = {WIDTH{1'b0}};
      fall = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/delay_pipe.sv
// Stallable, flushable register delay line with a runtime-selectable tap and
// edge detection on the selected output word.
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              TAP_W     = tap_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stg_q [DEPTH];
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] dout_s;
  logic             dout_valid_s;
  int               eff_idx;

  // Stage next-state: flush drops validity but keeps data; enable shifts by one.
  always_comb begin
    stg_d = stg_q;
    v_d   = v_q;
    if (flush) begin
      v_d = {DEPTH{1'b0}};
    end else if (en) begin
      stg_d[0] = din;
      v_d[0]   = din_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stg_d[i] = stg_q[i-1];
        v_d[i]   = v_q[i-1];
      end
    end else begin
      v_d = v_q;
    end
  end

  // Stage and valid registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg_q[i] <= RESET_VAL;
      end
      v_q <= {DEPTH{1'b0}};
    end else begin
      stg_q <= stg_d;
      v_q   <= v_d;
    end
  end

  // Tap mux as AND-OR over the registered stages; tap changes act immediately.
  always_comb begin
    eff_idx      = clamp_tap(int'(tap_sel), DEPTH) - 1;
    dout_s       = {WIDTH{1'b0}};
    dout_valid_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dout_s       = dout_s | (stg_q[i] & {WIDTH{(i == eff_idx)}});
      dout_valid_s = dout_valid_s | (v_q[i] & (i == eff_idx));
    end
  end

  assign dout       = dout_s;
  assign dout_valid = dout_valid_s;

  // History advances only on an enabled, unflushed edge that presents a valid word.
  edge_detect #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd     (en & ~flush & dout_valid_s),
    .clr     (flush),
    .d       (dout_s),
    .d_valid (dout_valid_s),
    .rise    (rise),
    .fall    (fall)
  );

endmodule

// File: tb/tb_delay_pipe.sv
// Scoreboard bench for delay_pipe: a queue-based history model produces the
// expected outputs after every edge; a negedge monitor pops and compares.
module tb_delay_pipe;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RV    = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       flush;
  logic [7:0] din;
  logic       din_valid;
  logic [2:0] tap_sel;
  logic [7:0] dout;
  logic       dout_valid;
  logic [7:0] rise;
  logic [7:0] fall;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: newest word at index 0 of the history queues.
  logic [7:0] m_d[$];
  logic       m_v[$];
  logic [7:0] m_last;
  logic       m_ok;
  exp_t       cur;
  logic       p_en;
  logic       p_flush;
  logic [7:0] p_din;
  logic       p_dv;

  delay_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .din        (din),
    .din_valid  (din_valid),
    .tap_sel    (tap_sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .rise       (rise),
    .fall       (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d = {};
    m_v = {};
    for (int i = 0; i < DEPTH; i++) begin
      m_d.push_back(RV);
      m_v.push_back(1'b0);
    end
    m_last = RV;
    m_ok   = 1'b0;
  endtask

  function automatic exp_t model_out(input logic [2:0] tap);
    exp_t e;
    int   t;
    t = int'(tap);
    if (t < 1) t = 1;
    if (t > DEPTH) t = DEPTH;
    e.d = m_d[t-1];
    e.v = m_v[t-1];
    if (e.v && m_ok) begin
      e.r = e.d & ~m_last;
      e.f = ~e.d & m_last;
    end else begin
      e.r = 8'h00;
      e.f = 8'h00;
    end
    return e;
  endfunction

  // One clock: the model consumes the inputs that were present at the edge,
  // then new inputs are applied and the resulting expectation is queued.
  task automatic step(input logic en_i, input logic fl_i, input logic [7:0] din_i,
                      input logic dv_i, input logic [2:0] tap_i);
    @(posedge clk);
    if (p_flush) begin
      foreach (m_v[i]) m_v[i] = 1'b0;
      m_ok = 1'b0;
    end else if (p_en) begin
      if (cur.v) begin
        m_last = cur.d;
        m_ok   = 1'b1;
      end
      m_d.push_front(p_din);
      m_v.push_front(p_dv);
      void'(m_d.pop_back());
      void'(m_v.pop_back());
    end
    #1;
    en = en_i; flush = fl_i; din = din_i; din_valid = dv_i; tap_sel = tap_i;
    p_en = en_i; p_flush = fl_i; p_din = din_i; p_dv = dv_i;
    cur = model_out(tap_i);
    sb_q.push_back(cur);
  endtask

  // Monitor: compare whenever the scoreboard holds an expectation for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("dout", 32'(dout), 32'(e.d));
      chk("dout_valid", 32'(dout_valid), 32'(e.v));
      chk("rise", 32'(rise), 32'(e.r));
      chk("fall", 32'(fall), 32'(e.f));
    end
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; flush = 1'b0; din = 8'h00; din_valid = 1'b0; tap_sel = 3'd1;
    p_en = 1'b0; p_flush = 1'b0; p_din = 8'h00; p_dv = 1'b0;
    model_reset();
    cur = model_out(3'd1);
    #1 rst_n = 1'b0;
    #2;
    chk("reset_dout", 32'(dout), 32'(RV));
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_rise", 32'(rise), 32'd0);
    chk("reset_fall", 32'(fall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency at tap 2 and tap 4.
    step(1'b1, 1'b0, 8'h11, 1'b1, 3'd2);
    step(1'b1, 1'b0, 8'h22, 1'b1, 3'd2);
    step(1'b1, 1'b0, 8'h33, 1'b1, 3'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 3'd2);
    step(1'b1, 1'b0, 8'h11, 1'b1, 3'd4);
    step(1'b1, 1'b0, 8'h22, 1'b1, 3'd4);
    step(1'b1, 1'b0, 8'h33, 1'b1, 3'd4);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 3'd4);

    // Stall mid-stream at tap 3, with din wiggling while stalled.
    step(1'b1, 1'b0, 8'h0F, 1'b1, 3'd3);
    step(1'b1, 1'b0, 8'hF0, 1'b1, 3'd3);
    step(1'b1, 1'b0, 8'h3C, 1'b1, 3'd3);
    step(1'b1, 1'b0, 8'hC3, 1'b1, 3'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'($urandom), 1'b1, 3'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h5A + 8'(i), 1'b1, 3'd3);

    // Flush with en=1 while four valid words are in flight, then probe every tap.
    step(1'b1, 1'b1, 8'h77, 1'b1, 3'd3);
    for (int t = 1; t <= 4; t++) step(1'b0, 1'b0, 8'h00, 1'b0, 3'(t));
    step(1'b1, 1'b0, 8'h99, 1'b1, 3'd2);
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd2);
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd2);

    // Clamp: tap 0 acts as 1, tap 7 as 4; switch 4 -> 1 mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h10 * 8'(i + 1), 1'b1, (i < 3) ? 3'd0 : 3'd7);
    step(1'b0, 1'b0, 8'h00, 1'b0, 3'd4);
    step(1'b0, 1'b0, 8'h00, 1'b0, 3'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 3'd7);

    // Edges at tap 2: 00, FF, FF, invalid gap, 00.
    step(1'b1, 1'b0, 8'h00, 1'b1, 3'd2);
    step(1'b1, 1'b0, 8'hFF, 1'b1, 3'd2);
    step(1'b1, 1'b0, 8'hFF, 1'b1, 3'd2);
    step(1'b1, 1'b0, 8'h81, 1'b0, 3'd2);
    step(1'b1, 1'b0, 8'h00, 1'b1, 3'd2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 3'd2);

    // Asynchronous reset mid-run, between edges.
    @(negedge clk);
    #1;
    en = 1'b0; flush = 1'b0; din_valid = 1'b0;
    p_en = 1'b0; p_flush = 1'b0; p_dv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_dout", 32'(dout), 32'(RV));
    chk("midreset_valid", 32'(dout_valid), 32'd0);
    chk("midreset_rise", 32'(rise), 32'd0);
    chk("midreset_fall", 32'(fall), 32'd0);
    model_reset();
    cur = model_out(tap_sel);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           8'($urandom), 1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
